// File: rtl/hex_pio_pkg.sv
// Shared definitions for the HEX display PIO with blink support.
// Holds the register word addresses and the STATUS bit positions.
package hex_pio_pkg;

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_SET    = 3'd1;
   localparam logic [2:0] ADDR_CLR    = 3'd2;
   localparam logic [2:0] ADDR_MASK   = 3'd3;
   localparam logic [2:0] ADDR_PERIOD = 3'd4;
   localparam logic [2:0] ADDR_STATUS = 3'd5;

   localparam int unsigned STATUS_PHASE_BIT = 0;
   localparam int unsigned STATUS_EN_BIT    = 1;

endpackage

// File: rtl/blink_prescaler.sv
// Blink prescaler: divides clk down to a square-wave phase signal.
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   period        half-period in clk cycles; 0 disables blinking
//   restart       forces the counter and phase back to zero (period reload)
//   phase         current blink phase, toggles every `period` cycles
//   enabled       high whenever period is non-zero
module blink_prescaler #(
   parameter int unsigned PERIOD_W = 26
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PERIOD_W-1:0] period,
   input  logic                restart,
   output logic                phase,
   output logic                enabled
);

   logic [PERIOD_W-1:0] cnt_q;
   logic                phase_q;

   assign enabled = (period != '0);
   assign phase   = phase_q;

   // A restart wins over a coincident wrap so a reload always begins in phase 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else if (restart || !enabled) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else if (cnt_q == period - PERIOD_W'(1)) begin
         cnt_q   <= '0;
         phase_q <= ~phase_q;
      end else begin
         cnt_q   <= cnt_q + PERIOD_W'(1);
      end
   end

endmodule

// File: rtl/hex_pio_blink.sv
// Avalon-MM output PIO for the seven-segment displays with per-bit blinking.
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   address       word address (DATA, SET, CLR, MASK, PERIOD, STATUS)
//   chipselect    slave select, qualifies writes only
//   write_n       active-low write strobe
//   writedata     write data; bits above the register width are ignored
//   readdata      combinational, zero-extended read data
//   out_port      registered display drive
module hex_pio_blink
   import hex_pio_pkg::*;
#(
   parameter int unsigned DATA_W       = 28,
   parameter int unsigned PERIOD_W     = 26,
   parameter int unsigned RESET_PERIOD = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [DATA_W-1:0] out_port
);

   logic                wr;
   logic                restart;
   logic                phase;
   logic                blink_en;
   logic [DATA_W-1:0]   wd_data;
   logic [PERIOD_W-1:0] wd_period;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   mask_q;
   logic [PERIOD_W-1:0] period_q;
   logic [DATA_W-1:0]   out_q;
   logic [DATA_W-1:0]   out_d;
   logic                unused_writedata;

   assign wr        = chipselect & ~write_n;
   assign restart   = wr && (address == ADDR_PERIOD);
   assign wd_data   = writedata[DATA_W-1:0];
   assign wd_period = writedata[PERIOD_W-1:0];

   // Upper writedata bits are deliberately dropped.
   assign unused_writedata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q   <= '0;
         mask_q   <= '0;
         period_q <= PERIOD_W'(RESET_PERIOD);
      end else if (wr) begin
         case (address)
            ADDR_DATA:   data_q   <= wd_data;
            ADDR_SET:    data_q   <= data_q | wd_data;
            ADDR_CLR:    data_q   <= data_q & ~wd_data;
            ADDR_MASK:   mask_q   <= wd_data;
            ADDR_PERIOD: period_q <= wd_period;
            default:     ;
         endcase
      end
   end

   blink_prescaler #(
      .PERIOD_W (PERIOD_W)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .period  (period_q),
      .restart (restart),
      .phase   (phase),
      .enabled (blink_en)
   );

   // Masked bits are blanked while phase is high.
   assign out_d = data_q & ~(mask_q & {DATA_W{phase}});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out_port = out_q;

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:   readdata = 32'(data_q);
         ADDR_MASK:   readdata = 32'(mask_q);
         ADDR_PERIOD: readdata = 32'(period_q);
         ADDR_STATUS: begin
            readdata[STATUS_PHASE_BIT] = phase;
            readdata[STATUS_EN_BIT]    = blink_en;
         end
         default:     readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_hex_pio_blink.sv
module tb_hex_pio_blink;

   localparam int unsigned DW = 28;
   localparam int unsigned PW = 26;
   localparam logic [31:0] PMASK = 32'h03FF_FFFF;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [DW-1:0] out_port;

   hex_pio_blink #(
      .DATA_W       (DW),
      .PERIOD_W     (PW),
      .RESET_PERIOD (0)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: phase derived from cycles elapsed since the last period load.
   logic [DW-1:0] m_data, m_mask, m_out;
   int unsigned   m_period, m_t;

   function automatic logic m_phase();
      if (m_period == 0) return 1'b0;
      return ((m_t / m_period) % 2) == 1;
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return 32'(m_data);
         3'd3:    return 32'(m_mask);
         3'd4:    return m_period;
         3'd5:    return {30'd0, (m_period != 0), m_phase()};
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      m_data = '0; m_mask = '0; m_period = 0; m_t = 0; m_out = '0;
   endtask

   task automatic m_edge(input logic w, input logic [2:0] a, input logic [31:0] wd);
      logic [DW-1:0] nxt;
      nxt = m_data & ~(m_phase() ? m_mask : '0);
      if (w) begin
         case (a)
            3'd0: m_data = wd[DW-1:0];
            3'd1: m_data = m_data | wd[DW-1:0];
            3'd2: m_data = m_data & ~wd[DW-1:0];
            3'd3: m_mask = wd[DW-1:0];
            default: ;
         endcase
      end
      if (w && a == 3'd4) begin
         m_period = wd & PMASK;
         m_t = 0;
      end else begin
         m_t++;
      end
      m_out = nxt;
   endtask

   task automatic bus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
      chipselect = cs; write_n = wn; address = a; writedata = wd;
      @(posedge clk);
      m_edge(cs && !wn, a, wd);
      #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
      bus(1'b1, 1'b0, a, wd);
   endtask

   task automatic idle();
      bus(1'b0, 1'b1, 3'd0, 32'd0);
   endtask

   task automatic test_reset();
      logic [2:0] addrs [4] = '{3'd0, 3'd3, 3'd4, 3'd5};
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
      m_reset();
      #23 reset_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (out_port !== '0) begin
         n_fail++; $display("FAIL reset_out: got %h want 0", out_port);
      end
      for (int i = 0; i < 4; i++) begin
         address = addrs[i]; #1;
         n_cmp++;
         if (readdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_read a=%0d: got %h want 0", addrs[i], readdata);
         end
      end
   endtask

   task automatic test_set_clr();
      wr_reg(3'd0, 32'h0FF_00FF);
      wr_reg(3'd1, 32'h000_0F00);
      wr_reg(3'd2, 32'h000_00FF);
      address = 3'd0; #1;
      n_cmp++;
      if (readdata !== 32'h0FF_0F00) begin
         n_fail++; $display("FAIL setclr_data: got %h want 0ff0f00", readdata);
      end
      idle();
      n_cmp++;
      if (out_port !== 28'h0FF_0F00) begin
         n_fail++; $display("FAIL setclr_out: got %h want 0ff0f00", out_port);
      end
      for (int a = 1; a <= 2; a++) begin
         address = 3'(a); #1;
         n_cmp++;
         if (readdata !== 32'd0) begin
            n_fail++; $display("FAIL setclr_wo_read a=%0d: got %h want 0", a, readdata);
         end
      end
   endtask

   task automatic test_blink();
      wr_reg(3'd0, 32'h0FFF_FFFF);
      wr_reg(3'd3, 32'h0000_007F);
      wr_reg(3'd4, 32'd4);
      for (int i = 0; i < 24; i++) begin
         idle();
         n_cmp++;
         if (out_port !== m_out || (out_port !== 28'hFFF_FFFF && out_port !== 28'hFFF_FF80)) begin
            n_fail++; $display("FAIL blink_out cyc=%0d: got %h want %h", i, out_port, m_out);
         end
         address = 3'd5; #1;
         n_cmp++;
         if (readdata !== m_read(3'd5) || readdata[1] !== 1'b1) begin
            n_fail++; $display("FAIL blink_status cyc=%0d: got %h want %h", i, readdata, m_read(3'd5));
         end
      end
   endtask

   task automatic test_restart();
      logic [1:0] want [3] = '{2'b10, 2'b10, 2'b11};
      int guard;
      wr_reg(3'd4, 32'd10);
      repeat (7) idle();
      wr_reg(3'd4, 32'd3);
      address = 3'd5; #1;
      n_cmp++;
      if (readdata[1:0] !== 2'b10) begin
         n_fail++; $display("FAIL restart_phase0: got %b want 10", readdata[1:0]);
      end
      for (int i = 0; i < 3; i++) begin
         idle();
         address = 3'd5; #1;
         n_cmp++;
         if (readdata[1:0] !== want[i]) begin
            n_fail++; $display("FAIL restart_toggle cyc=%0d: got %b want %b", i, readdata[1:0], want[i]);
         end
      end
      // Land a PERIOD write on the edge where phase would otherwise go 0->1.
      guard = 0;
      while ((m_t % 6) != 2 && guard < 20) begin
         idle(); guard++;
      end
      wr_reg(3'd4, 32'd3);
      address = 3'd5; #1;
      n_cmp++;
      if (readdata[1:0] !== 2'b10) begin
         n_fail++; $display("FAIL restart_on_wrap: got %b want 10", readdata[1:0]);
      end
   endtask

   task automatic test_disable();
      int guard;
      logic [DW-1:0] d;
      d = DW'($urandom) | 28'h1;
      wr_reg(3'd0, 32'(d));
      wr_reg(3'd3, 32'h0FFF_FFFF);
      wr_reg(3'd4, 32'd2);
      guard = 0;
      while (!m_phase() && guard < 20) begin
         idle(); guard++;
      end
      n_cmp++;
      if (!m_phase()) begin
         n_fail++; $display("FAIL disable_reach_phase1: got 0 want 1");
      end
      wr_reg(3'd4, 32'd0);
      idle();
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (out_port !== d) begin
            n_fail++; $display("FAIL disable_out cyc=%0d: got %h want %h", i, out_port, d);
         end
         address = 3'd5; #1;
         n_cmp++;
         if (readdata !== 32'd0) begin
            n_fail++; $display("FAIL disable_status cyc=%0d: got %h want 0", i, readdata);
         end
         idle();
      end
   endtask

   task automatic test_random();
      logic [2:0]  a, ra;
      logic        cs, wn;
      logic [31:0] wd;
      for (int i = 0; i < 300; i++) begin
         a  = 3'($urandom_range(0, 7));
         cs = ($urandom_range(0, 3) != 0);
         wn = ($urandom_range(0, 2) == 0);
         wd = $urandom;
         if (a == 3'd4) wd = $urandom_range(0, 5);
         bus(cs, wn, a, wd);
         n_cmp++;
         if (out_port !== m_out) begin
            n_fail++; $display("FAIL random_out cyc=%0d: got %h want %h", i, out_port, m_out);
         end
         ra = 3'($urandom_range(0, 7));
         address = ra; #1;
         n_cmp++;
         if (readdata !== m_read(ra)) begin
            n_fail++; $display("FAIL random_read cyc=%0d a=%0d: got %h want %h", i, ra, readdata, m_read(ra));
         end
      end
   endtask

   task automatic test_async_reset();
      int guard;
      wr_reg(3'd0, 32'h0FFF_FFFF);
      wr_reg(3'd3, 32'h0000_00FF);
      wr_reg(3'd4, 32'd2);
      guard = 0;
      while (!(m_phase() && m_out == 28'hFFF_FF00) && guard < 20) begin
         idle(); guard++;
      end
      n_cmp++;
      if (out_port !== 28'hFFF_FF00) begin
         n_fail++; $display("FAIL arst_pre_out: got %h want fffff00", out_port);
      end
      #3 reset_n = 1'b0;
      address = 3'd5;
      #1;
      m_reset();
      n_cmp++;
      if (out_port !== '0) begin
         n_fail++; $display("FAIL arst_out: got %h want 0", out_port);
      end
      n_cmp++;
      if (readdata !== 32'd0) begin
         n_fail++; $display("FAIL arst_status: got %h want 0", readdata);
      end
      #10 reset_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         idle();
         address = 3'd5; #1;
         n_cmp++;
         if (readdata !== 32'd0 || out_port !== '0) begin
            n_fail++; $display("FAIL arst_after cyc=%0d: status %h out %h want 0 0", i, readdata, out_port);
         end
      end
   endtask

   initial begin
      test_reset();
      test_set_clr();
      test_blink();
      test_restart();
      test_disable();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
